// File: rtl/dma_ctrl_if.sv
// CPU-side and system-bus signals of the DMA engine, bundled for dma_ctrl.
// master = SoC side (CPU + read-data mux), slave = dma_ctrl.
interface dma_ctrl_if;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_we;
    logic [15:0] i_cpu_wdata;
    logic [15:0] i_bus_rdata;
    logic [15:0] o_bus_addr;
    logic        o_bus_we;
    logic [15:0] o_bus_wdata;
    logic [15:0] o_reg_rdata;
    logic        o_cpu_ce;
    logic        o_int;

    modport master (
        output i_cpu_addr, i_cpu_we, i_cpu_wdata, i_bus_rdata,
        input  o_bus_addr, o_bus_we, o_bus_wdata, o_reg_rdata, o_cpu_ce, o_int
    );

    modport slave (
        input  i_cpu_addr, i_cpu_we, i_cpu_wdata, i_bus_rdata,
        output o_bus_addr, o_bus_we, o_bus_wdata, o_reg_rdata, o_cpu_ce, o_int
    );
endinterface

// File: rtl/dma_ctrl.sv
// Single-channel mem-to-mem DMA and system-bus arbiter, registers at 0x0440-0x0443.
// Optional macro DMA_FAIR_EN: burst counter, YIELD cycle every BURST words, ABORT.
module dma_ctrl #(
    parameter int RD_LAT = 0,
    parameter int BURST  = 8
) (
    input  logic      i_clk,
    input  logic      i_reset,
    dma_ctrl_if.slave bus
);
    localparam logic [15:0] A_SRC  = 16'h0440;
    localparam logic [15:0] A_DST  = 16'h0441;
    localparam logic [15:0] A_LEN  = 16'h0442;
    localparam logic [15:0] A_CTRL = 16'h0443;

    if (RD_LAT != 0 && RD_LAT != 1) begin : g_bad_rd_lat
        $error("dma_ctrl: RD_LAT must be 0 or 1");
    end
    if (BURST < 1 || BURST > 255) begin : g_bad_burst
        $error("dma_ctrl: BURST must be 1..255");
    end

`ifdef DMA_FAIR_EN
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, YIELD} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, RDW, WR} state_t;
`endif

    state_t      state;
    logic [15:0] src, dst, len, data;
    logic        done, ie, src_fix, dst_fix;
    logic        cpu_ce, busy, reg_we, ctrl_we;
    logic [15:0] wd;

`ifdef DMA_FAIR_EN
    logic [7:0] bcnt;
    logic [7:0] bcnt_nxt;
    assign bcnt_nxt = bcnt + 8'd1;
    assign cpu_ce   = (state == IDLE) || (state == YIELD);
`else
    assign cpu_ce   = (state == IDLE);
`endif

    // Only CPU-owned cycles decode registers, so DMA writes to 0x044x hit memory only.
    assign busy    = (state != IDLE);
    assign reg_we  = cpu_ce && bus.i_cpu_we;
    assign ctrl_we = reg_we && (bus.i_cpu_addr == A_CTRL);
    assign wd      = bus.i_cpu_wdata;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            data    <= '0;
            done    <= 1'b0;
            ie      <= 1'b0;
            src_fix <= 1'b0;
            dst_fix <= 1'b0;
`ifdef DMA_FAIR_EN
            bcnt    <= '0;
`endif
        end else begin
            if (reg_we && !busy) begin
                case (bus.i_cpu_addr)
                    A_SRC:   src <= wd;
                    A_DST:   dst <= wd;
                    A_LEN:   len <= wd;
                    default: ;
                endcase
            end
            if (ctrl_we) begin
                ie      <= wd[2];
                src_fix <= wd[3];
                dst_fix <= wd[4];
                if (wd[1]) done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ctrl_we && wd[0]) begin
                        if (len == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            done  <= 1'b0;
                            state <= RD;
`ifdef DMA_FAIR_EN
                            bcnt  <= '0;
`endif
                        end
                    end
                end
                RD: begin
                    if (RD_LAT == 0) begin
                        data  <= bus.i_bus_rdata;
                        state <= WR;
                    end else begin
                        state <= RDW;
                    end
                end
                RDW: begin
                    data  <= bus.i_bus_rdata;
                    state <= WR;
                end
                WR: begin
                    if (!src_fix) src <= src + 16'd1;
                    if (!dst_fix) dst <= dst + 16'd1;
                    len <= len - 16'd1;
                    if (len == 16'd1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
`ifdef DMA_FAIR_EN
                        if (bcnt_nxt == BURST[7:0]) begin
                            state <= YIELD;
                            bcnt  <= '0;
                        end else begin
                            state <= RD;
                            bcnt  <= bcnt_nxt;
                        end
`else
                        state <= RD;
`endif
                    end
                end
`ifdef DMA_FAIR_EN
                YIELD: begin
                    if (ctrl_we && wd[7]) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_cpu_ce    = cpu_ce;
    assign bus.o_bus_addr  = cpu_ce ? bus.i_cpu_addr  : ((state == WR) ? dst : src);
    assign bus.o_bus_we    = cpu_ce ? bus.i_cpu_we    : (state == WR);
    assign bus.o_bus_wdata = cpu_ce ? bus.i_cpu_wdata : data;
    assign bus.o_int       = done & ie;

    always_comb begin
        bus.o_reg_rdata = 16'h0000;
        case (bus.i_cpu_addr)
            A_SRC:   bus.o_reg_rdata = src;
            A_DST:   bus.o_reg_rdata = dst;
            A_LEN:   bus.o_reg_rdata = len;
            A_CTRL:  bus.o_reg_rdata = {11'd0, dst_fix, src_fix, ie, done, busy};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: u0 has RD_LAT=0, u1 has RD_LAT=1 and BURST=2.
// A negedge monitor pops expected DMA bus ops; stimulus pushes them before START.
module tb_dma_ctrl;
  typedef struct packed {logic we; logic [15:0] addr; logic [15:0] data;} bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] c_addr, c_wdata;
  logic        c_we;
  int          sel;
  int          n_vec = 0, n_err = 0;
  int          lo0 = 0, lo1 = 0;
  logic        prv0 = 1'b0, prv1 = 1'b0;
  bus_t        q0[$], q1[$];
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  logic [15:0] rd1 = 16'h0;

  always #10 clk = ~clk;

  dma_ctrl_if if0 ();
  dma_ctrl_if if1 ();

  assign if0.i_cpu_addr  = c_addr;
  assign if0.i_cpu_we    = c_we && (sel == 0);
  assign if0.i_cpu_wdata = c_wdata;
  assign if0.i_bus_rdata = mem0[if0.o_bus_addr];
  assign if1.i_cpu_addr  = c_addr;
  assign if1.i_cpu_we    = c_we && (sel == 1);
  assign if1.i_cpu_wdata = c_wdata;
  assign if1.i_bus_rdata = rd1;

  dma_ctrl #(.RD_LAT(0), .BURST(8)) u0 (.i_clk(clk), .i_reset(rst), .bus(if0));
  dma_ctrl #(.RD_LAT(1), .BURST(2)) u1 (.i_clk(clk), .i_reset(rst), .bus(if1));

  // memories: u0 sees combinational read data, u1 one cycle late
  always @(posedge clk) begin
    if (if0.o_bus_we) mem0[if0.o_bus_addr] <= if0.o_bus_wdata;
    if (if1.o_bus_we) mem1[if1.o_bus_addr] <= if1.o_bus_wdata;
    rd1 <= mem1[if1.o_bus_addr];
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic we, input logic [15:0] a, input logic [15:0] w,
                     input logic prv);
    bus_t e, g;
    if (!we && prv) return;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_vec++; n_err++;
      $display("FAIL dma%0d unexpected bus op: we=%0b addr=%h", d, we, a);
      return;
    end
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    g = '{we: we, addr: a, data: (we ? w : 16'h0)};
    if (!e.we) e.data = 16'h0;
    chk($sformatf("dma%0d bus op", d), 40'(g), 40'(e));
  endtask

  always @(negedge clk) begin
    if (!if0.o_cpu_ce) begin
      lo0 = lo0 + 1;
      mon(0, if0.o_bus_we, if0.o_bus_addr, if0.o_bus_wdata, prv0);
    end
    if (!if1.o_cpu_ce) begin
      lo1 = lo1 + 1;
      mon(1, if1.o_bus_we, if1.o_bus_addr, if1.o_bus_wdata, prv1);
    end
    prv0 = !if0.o_cpu_ce && !if0.o_bus_we;
    prv1 = !if1.o_cpu_ce && !if1.o_bus_we;
  end

  task automatic exp_word(input int d, input logic [15:0] s, input logic [15:0] t,
                          input logic [15:0] v);
    bus_t r, w;
    r = '{we: 1'b0, addr: s, data: 16'h0};
    w = '{we: 1'b1, addr: t, data: v};
    if (d == 0) begin q0.push_back(r); q0.push_back(w); end
    else        begin q1.push_back(r); q1.push_back(w); end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] v);
    c_addr = a; c_wdata = v; c_we = 1'b1;
    @(negedge clk);
    c_we = 1'b0;
  endtask

  task automatic rdreg(input logic [15:0] a, output logic [15:0] v);
    c_addr = a;
    #1;
    v = (sel == 0) ? if0.o_reg_rdata : if1.o_reg_rdata;
  endtask

  task automatic chk_reg(input string nm, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v;
    rdreg(a, v);
    chk(nm, 40'(v), 40'(exp));
  endtask

  task automatic wait_done(input string nm);
    logic [15:0] v;
    int k;
    for (k = 0; k < 100; k++) begin
      rdreg(16'h0443, v);
      if (!v[0]) break;
      @(negedge clk);
    end
    if (k == 100) begin
      n_vec++; n_err++;
      $display("FAIL %s: BUSY still set after 100 cycles, want 0", nm);
    end
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] t, input logic [15:0] n);
    cpu_wr(16'h0440, s);
    cpu_wr(16'h0441, t);
    cpu_wr(16'h0442, n);
  endtask

  initial begin
    int base;
    logic [17:0] pat, pat_exp;
    c_addr = '0; c_wdata = '0; c_we = 1'b0; sel = 0; rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d;
      for (int i = 0; i < 4; i++) chk_reg("reset reg", 16'h0440 + 16'(i), 16'h0);
    end
    chk("reset ce", 40'(if0.o_cpu_ce), 40'h1);
    chk("reset int", 40'(if0.o_int), 40'h0);
    rst = 1'b0;

    // basic 4-word copy, RD_LAT=0
    @(negedge clk); sel = 0;
    for (int i = 0; i < 4; i++) mem0[16'h0010 + 16'(i)] = 16'h00A1 + 16'(i);
    setup(16'h0010, 16'h0100, 16'd4);
    for (int i = 0; i < 4; i++) exp_word(0, 16'h0010 + 16'(i), 16'h0100 + 16'(i), 16'h00A1 + 16'(i));
    base = lo0;
    cpu_wr(16'h0443, 16'h0001);
    wait_done("t1 done");
    chk("t1 ce low cycles", 40'(lo0 - base), 40'd8);
    chk_reg("t1 ctrl", 16'h0443, 16'h0002);
    chk_reg("t1 len", 16'h0442, 16'h0000);
    chk_reg("t1 src", 16'h0440, 16'h0014);
    chk_reg("t1 dst", 16'h0441, 16'h0104);
    for (int i = 0; i < 4; i++) chk("t1 mem", 40'(mem0[16'h0100 + 16'(i)]), 40'(16'h00A1 + 16'(i)));
    chk("t1 queue drained", 40'(q0.size()), 40'd0);

    // RD_LAT=1 with IE
    @(negedge clk); sel = 1;
    for (int i = 0; i < 3; i++) mem1[16'h0020 + 16'(i)] = 16'h00B1 + 16'(i);
    setup(16'h0020, 16'h0120, 16'd3);
    for (int i = 0; i < 3; i++) exp_word(1, 16'h0020 + 16'(i), 16'h0120 + 16'(i), 16'h00B1 + 16'(i));
    base = lo1;
    cpu_wr(16'h0443, 16'h0005);
    wait_done("t2 done");
    chk("t2 ce low cycles", 40'(lo1 - base), 40'd9);
    chk("t2 int set", 40'(if1.o_int), 40'h1);
    chk_reg("t2 ctrl", 16'h0443, 16'h0006);
    cpu_wr(16'h0443, 16'h0002);
    #1 chk("t2 int cleared", 40'(if1.o_int), 40'h0);
    chk_reg("t2 ctrl after w1c", 16'h0443, 16'h0000);
    for (int i = 0; i < 3; i++) chk("t2 mem", 40'(mem1[16'h0120 + 16'(i)]), 40'(16'h00B1 + 16'(i)));
    chk("t2 queue drained", 40'(q1.size()), 40'd0);

    // LEN=0 start: DONE at once, no bus cycles
    @(negedge clk); sel = 0;
    cpu_wr(16'h0443, 16'h0002);
    chk_reg("t3 ctrl cleared", 16'h0443, 16'h0000);
    base = lo0;
    cpu_wr(16'h0443, 16'h0001);
    chk_reg("t3 ctrl done", 16'h0443, 16'h0002);
    repeat (3) @(negedge clk);
    chk("t3 ce never low", 40'(lo0 - base), 40'd0);
    chk("t3 int", 40'(if0.o_int), 40'h0);

    // address wrap with DST_FIX
    @(negedge clk); sel = 0;
    mem0[16'hFFFE] = 16'h00C1; mem0[16'hFFFF] = 16'h00C2; mem0[16'h0000] = 16'h00C3;
    setup(16'hFFFE, 16'h0200, 16'd3);
    exp_word(0, 16'hFFFE, 16'h0200, 16'h00C1);
    exp_word(0, 16'hFFFF, 16'h0200, 16'h00C2);
    exp_word(0, 16'h0000, 16'h0200, 16'h00C3);
    base = lo0;
    cpu_wr(16'h0443, 16'h0011);
    wait_done("t4 done");
    chk("t4 ce low cycles", 40'(lo0 - base), 40'd6);
    chk_reg("t4 ctrl", 16'h0443, 16'h0012);
    chk_reg("t4 src", 16'h0440, 16'h0001);
    chk_reg("t4 dst", 16'h0441, 16'h0200);
    chk_reg("t4 len", 16'h0442, 16'h0000);
    chk("t4 mem", 40'(mem0[16'h0200]), 40'h00C3);
    chk("t4 queue drained", 40'(q0.size()), 40'd0);

`ifdef DMA_FAIR_EN
    // BURST=2, LEN=5: YIELD after words 2 and 4
    @(negedge clk); sel = 1;
    for (int i = 0; i < 5; i++) mem1[16'h0030 + 16'(i)] = 16'h00E1 + 16'(i);
    setup(16'h0030, 16'h0130, 16'd5);
    for (int i = 0; i < 5; i++) exp_word(1, 16'h0030 + 16'(i), 16'h0130 + 16'(i), 16'h00E1 + 16'(i));
    cpu_wr(16'h0443, 16'h0001);
    pat_exp = '0;
    pat_exp[6] = 1'b1; pat_exp[13] = 1'b1; pat_exp[17] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1 pat[i] = if1.o_cpu_ce;
      @(negedge clk);
    end
    chk("t5 ce pattern", 40'(pat), 40'(pat_exp));
    chk_reg("t5 ctrl", 16'h0443, 16'h0002);
    chk("t5 queue drained", 40'(q1.size()), 40'd0);

    // ABORT in the first YIELD
    @(negedge clk);
    setup(16'h0030, 16'h0140, 16'd5);
    for (int i = 0; i < 2; i++) exp_word(1, 16'h0030 + 16'(i), 16'h0140 + 16'(i), 16'h00E1 + 16'(i));
    cpu_wr(16'h0443, 16'h0001);
    repeat (6) @(negedge clk);
    #1 chk("t5 yield ce", 40'(if1.o_cpu_ce), 40'h1);
    cpu_wr(16'h0443, 16'h0080);
    chk_reg("t5 abort ctrl", 16'h0443, 16'h0002);
    chk_reg("t5 abort len", 16'h0442, 16'h0003);
    chk_reg("t5 abort src", 16'h0440, 16'h0032);
    chk_reg("t5 abort dst", 16'h0441, 16'h0142);
    repeat (2) @(negedge clk);
    chk("t5 abort queue drained", 40'(q1.size()), 40'd0);
`endif

    // reset asserted during WR
    @(negedge clk); sel = 0;
    mem0[16'h0050] = 16'h00D1;
    setup(16'h0050, 16'h0150, 16'd4);
    exp_word(0, 16'h0050, 16'h0150, 16'h00D1);
    cpu_wr(16'h0443, 16'h0001);
    @(negedge clk);
    #2 rst = 1'b1; c_addr = 16'h0443; c_wdata = 16'h5A5A; c_we = 1'b1;
    #1 chk("t6 ce in reset", 40'(if0.o_cpu_ce), 40'h1);
    chk("t6 bus we follows cpu", 40'(if0.o_bus_we), 40'h1);
    chk("t6 bus addr follows cpu", 40'(if0.o_bus_addr), 40'h0443);
    c_we = 1'b0;
    #1 chk("t6 bus we low", 40'(if0.o_bus_we), 40'h0);
    for (int i = 0; i < 4; i++) chk_reg("t6 reg in reset", 16'h0440 + 16'(i), 16'h0);
    @(posedge clk);
    #1 chk("t6 no partial write", 40'(mem0[16'h0150]), 40'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6 queue drained", 40'(q0.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Single-channel memory-to-memory DMA engine and bus arbiter for the toy SoC. Sits between the CPU and the shared 16-bit system bus: the CPU programs it through four word registers at 0x0440–0x0443, and while a transfer runs the block drives the system bus and stalls the CPU through its clock enable. Completion raises a level interrupt, which is routed to a free interrupt-controller line.

## Interface
Parameters:
- RD_LAT, 0, cycles from read address on the bus to valid i_bus_rdata (legal values 0 or 1).
- BURST, 8, words moved before the CPU is given one cycle (used only with DMA_FAIR_EN; legal range 1–255).

Ports:
- i_clk  in  1  system clock; everything is rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cpu_addr  in  16  CPU bus address.
- i_cpu_we  in  1  CPU write strobe.
- i_cpu_wdata  in  16  CPU write data.
- i_bus_rdata  in  16  system read-data mux output.
- o_bus_addr  out  16  system bus address (CPU or DMA).
- o_bus_we  out  1  system bus write strobe.
- o_bus_wdata  out  16  system bus write data.
- o_reg_rdata  out  16  register readback for 0x0440–0x0443; 0 elsewhere.
- o_cpu_ce  out  1  CPU clock enable; 0 while the DMA owns the bus.
- o_int  out  1  done interrupt, level.

## Operation
- Registers:
  - 0x0440 SRC.
  - 0x0441 DST.
  - 0x0442 LEN (remaining words).
  - 0x0443 CTRL: bit0 START (write) / BUSY (read), bit1 DONE (sticky, write-1-to-clear), bit2 IE, bit3 SRC_FIX, bit4 DST_FIX, bit7 ABORT (write-only).
  - Other CTRL bits read as 0.
- Register writes are decoded from i_cpu_* only when o_cpu_ce=1. While BUSY, writes to SRC, DST and LEN are ignored.
- Bus ownership:
  - When o_cpu_ce=1, o_bus_* = i_cpu_*.
  - Otherwise the DMA drives o_bus_*.
- A CTRL write with START=1 while IDLE sets BUSY and clears DONE. START while BUSY is ignored.
- LEN=0 at START: no bus cycles occur, o_cpu_ce never drops, and DONE is set at the same edge.
- FSM states: IDLE, RD, RDW, WR, YIELD.
  - IDLE→RD on a START with nonzero LEN.
  - RD: o_bus_addr=SRC, we=0.
    - If RD_LAT=0: capture i_bus_rdata at the end of RD, then go to WR.
    - If RD_LAT=1: go to RDW.
  - RDW: the address is held at SRC; capture i_bus_rdata at the end of the cycle, then go to WR.
  - WR: o_bus_addr=DST, we=1, wdata=captured word. At the end of WR:
    - SRC+=1 unless SRC_FIX; DST+=1 unless DST_FIX; LEN-=1.
    - If the new LEN is 0: go to IDLE and set DONE.
    - Otherwise go to YIELD (DMA_FAIR_EN and burst count reached) or RD.
  - YIELD: exactly one cycle with o_cpu_ce=1, then RD. A CPU ABORT write in this cycle sends the FSM to IDLE and sets DONE, leaving SRC, DST and LEN live.
- Addresses wrap modulo 2^16 (0xFFFF+1 = 0x0000). The DMA may target any address, including its own registers; the DMA's own bus writes are not decoded as register writes.
- Readback: SRC, DST and LEN return live values. Readback is combinational on i_cpu_addr.
- o_int = DONE & IE. Writing DONE=1 together with START clears DONE and starts the transfer.

## Timing
- Reset values: FSM IDLE; SRC, DST, LEN, CTRL = 0; o_cpu_ce=1; o_int=0. o_bus_* follow i_cpu_*.
- Reset mid-transfer aborts immediately. No partial write completes after reset assertion.
- o_cpu_ce is decoded from the state register only, with no input-to-output combinational path:
  - o_cpu_ce = 1 in IDLE and YIELD.
  - o_cpu_ce = 0 in RD, RDW and WR.
- Transfer latency with the START write in cycle T:
  - The first RD is in cycle T+1.
  - Each word costs 2+RD_LAT cycles, plus 1 per YIELD.
  - DONE and o_cpu_ce=1 take effect in the cycle after the last WR.

## Configuration
- DMA_FAIR_EN defined:
  - The burst counter is present and resets at START and after each YIELD.
  - After every BURST completed words with LEN still nonzero, the FSM inserts YIELD.
  - ABORT is honored.
- DMA_FAIR_EN undefined:
  - No YIELD state and no burst counter; BURST is unused.
  - The CPU is stalled for the whole transfer.
  - The ABORT bit is ignored.

## Test plan
- RD_LAT=0; SRC=0x0010, DST=0x0100, LEN=4; memory[0x10..0x13]=A1..A4; START. Required: o_cpu_ce low for exactly 8 cycles; memory[0x100..0x103]=A1..A4; CTRL reads 0x0002; LEN reads 0.
- RD_LAT=1, IE=1, LEN=3. Required: o_cpu_ce low for 9 cycles; o_int=1 after completion; writing CTRL=0x0002 drops o_int next cycle.
- LEN=0 START. Required: DONE=1 on the next read; o_cpu_ce never 0; no o_bus_we from the DMA.
- SRC=0xFFFE, DST=0x0200, LEN=3, DST_FIX=1. Required: reads from 0xFFFE, 0xFFFF, 0x0000; all three writes go to 0x0200; final SRC reads 0x0001.
- DMA_FAIR_EN, BURST=2, LEN=5. Required: YIELD cycles after words 2 and 4. With ABORT written in the first YIELD: DONE=1 and LEN reads 3.
- Assert i_reset during a WR cycle. Required: o_cpu_ce=1 and o_bus_we follows i_cpu_we in the same cycle; all registers read 0.
